// File: rtl/sorter_pkg.sv
// Shared helpers for the streaming sorter: index width and sign-aware key compare.
// Keys are widened to 64 bits before comparison, so N must not exceed 64.
package sorter_pkg;

  localparam int KEY_MAX_W = 64;

  function automatic int idx_w(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  // Sign- or zero-extend an n-bit key held in the low bits of k.
  function automatic logic [KEY_MAX_W-1:0] key_ext(input logic [KEY_MAX_W-1:0] k,
                                                   input int n, input logic is_signed);
    logic [KEY_MAX_W-1:0] r;
    r = k;
    for (int i = 0; i < KEY_MAX_W; i++) begin
      if (i >= n) r[i] = is_signed & k[n-1];
    end
    return r;
  endfunction

  function automatic logic key_gt(input logic [KEY_MAX_W-1:0] a,
                                  input logic [KEY_MAX_W-1:0] b,
                                  input logic is_signed);
    if (is_signed) return $signed(a) > $signed(b);
    else return a > b;
  endfunction

endpackage

// File: rtl/m_sort_stage.sv
// One registered odd-even transposition stage; index lanes exist only with SORTER_IDX_EN.
module m_sort_stage
  import sorter_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int SIGNED = 0,
  parameter int ODD    = 0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Adv,
  input  logic                   valid_i,
  input  logic                   desc_i,
  input  logic [N-1:0]           key_i [M],
`ifdef SORTER_IDX_EN
  input  logic [idx_w(M)-1:0]    idx_i [M],
  output logic [idx_w(M)-1:0]    idx_o [M],
`endif
  output logic                   valid_o,
  output logic                   desc_o,
  output logic [N-1:0]           key_o [M]
);

  logic         valid_q;
  logic         desc_q;
  logic [N-1:0] key_q [M];
  logic [N-1:0] key_d [M];
`ifdef SORTER_IDX_EN
  logic [idx_w(M)-1:0] idx_q [M];
  logic [idx_w(M)-1:0] idx_d [M];
`endif

  // Strict inversion only, so equal keys never move and the sort stays stable.
  function automatic logic inverted(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic desc);
    logic [KEY_MAX_W-1:0] ea;
    logic [KEY_MAX_W-1:0] eb;
    ea = key_ext(KEY_MAX_W'(a), N, SIGNED != 0);
    eb = key_ext(KEY_MAX_W'(b), N, SIGNED != 0);
    return desc ? key_gt(eb, ea, SIGNED != 0) : key_gt(ea, eb, SIGNED != 0);
  endfunction

  always_comb begin
    key_d = key_i;
`ifdef SORTER_IDX_EN
    idx_d = idx_i;
`endif
    for (int p = ODD; p + 1 < M; p += 2) begin
      if (inverted(key_i[p], key_i[p+1], desc_i)) begin
        key_d[p]   = key_i[p+1];
        key_d[p+1] = key_i[p];
`ifdef SORTER_IDX_EN
        idx_d[p]   = idx_i[p+1];
        idx_d[p+1] = idx_i[p];
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      desc_q  <= 1'b0;
      for (int i = 0; i < M; i++) begin
        key_q[i] <= '0;
`ifdef SORTER_IDX_EN
        idx_q[i] <= '0;
`endif
      end
    end else if (Adv) begin
      valid_q <= valid_i;
      desc_q  <= desc_i;
      key_q   <= key_d;
`ifdef SORTER_IDX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign desc_o  = desc_q;
  assign key_o   = key_q;
`ifdef SORTER_IDX_EN
  assign idx_o   = idx_q;
`endif

endmodule

// File: rtl/m_stream_sorter.sv
// Fully pipelined M-stage stable sorter with valid/ready flow control.
// SORTER_IDX_EN adds per-key origin indices and the YIdx output.
module m_stream_sorter
  import sorter_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int SIGNED = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                InValid,
  output logic                InReady,
  input  logic                InDescend,
  input  logic [N-1:0]        X [M],
  output logic                OutValid,
  input  logic                OutReady,
  output logic                OutDescend,
`ifdef SORTER_IDX_EN
  output logic [idx_w(M)-1:0] YIdx [M],
`endif
  output logic [N-1:0]        Y [M]
);

  typedef logic [N-1:0] key_t;

  logic adv;
  logic valid_c [M+1];
  logic desc_c  [M+1];
  key_t key_c   [M+1][M];

`ifdef SORTER_IDX_EN
  localparam int IW = idx_w(M);
  typedef logic [IW-1:0] idx_t;
  idx_t idx_c [M+1][M];

  for (genvar g = 0; g < M; g++) begin : g_idx0
    assign idx_c[0][g] = IW'(g);
  end
`endif

  // Whole pipeline moves in lockstep; it only freezes behind a refused output.
  assign adv     = !OutValid || OutReady;
  assign InReady = adv;

  assign valid_c[0] = InValid;
  assign desc_c[0]  = InDescend;
  assign key_c[0]   = X;

  for (genvar s = 0; s < M; s++) begin : g_stage
    m_sort_stage #(
      .N      (N),
      .M      (M),
      .SIGNED (SIGNED),
      .ODD    (s % 2)
    ) u_stage (
      .Clk     (Clk),
      .Reset   (Reset),
      .Adv     (adv),
      .valid_i (valid_c[s]),
      .desc_i  (desc_c[s]),
      .key_i   (key_c[s]),
`ifdef SORTER_IDX_EN
      .idx_i   (idx_c[s]),
      .idx_o   (idx_c[s+1]),
`endif
      .valid_o (valid_c[s+1]),
      .desc_o  (desc_c[s+1]),
      .key_o   (key_c[s+1])
    );
  end

  assign OutValid   = valid_c[M];
  assign OutDescend = desc_c[M];
  assign Y          = key_c[M];
`ifdef SORTER_IDX_EN
  assign YIdx       = idx_c[M];
`endif

endmodule
